// File: rtl/reaction_timer_core_if.sv
// ---------------------------------------------------------------------------
// reaction_timer_core_if
//
// Bundles the switch inputs and display/status outputs of the reaction timer
// so the core and whatever drives it (board glue or a bench) share one
// connection point.
//
//   start       level from the start switch; a rising edge arms a trial
//   button      level from the reaction button; a rising edge is a press
//   best_clr    synchronous pulse that resets the best record to all 9s
//   result_bcd  current / last reaction time, digit 0 (units) in [3:0]
//   best_bcd    best valid reaction time seen since reset or clear
//   go_led      lit while the player should react
//   busy        a trial is in progress (armed or running)
//   foul        sticky: the last trial was a false start
//   timeout     sticky: the last trial saturated the display
//   new_best    one-cycle pulse when best_bcd takes a new record
//
// Modports:
//   master  drives the switches, observes the results (board glue / bench)
//   slave   the timer core itself
// ---------------------------------------------------------------------------
interface reaction_timer_core_if #(
  parameter int DIGITS = 4
);

  logic                  start;
  logic                  button;
  logic                  best_clr;
  logic [4*DIGITS-1:0]   result_bcd;
  logic [4*DIGITS-1:0]   best_bcd;
  logic                  go_led;
  logic                  busy;
  logic                  foul;
  logic                  timeout;
  logic                  new_best;

  modport master (
    output start,
    output button,
    output best_clr,
    input  result_bcd,
    input  best_bcd,
    input  go_led,
    input  busy,
    input  foul,
    input  timeout,
    input  new_best
  );

  modport slave (
    input  start,
    input  button,
    input  best_clr,
    output result_bcd,
    output best_bcd,
    output go_led,
    output busy,
    output foul,
    output timeout,
    output new_best
  );

endinterface

// File: rtl/reaction_timer_core.sv
// ---------------------------------------------------------------------------
// reaction_timer_core
//
// Reaction-timer engine. A start edge arms a trial and loads a delay made of
// a fixed part plus a pseudo-random part (from a free-running LFSR). When the
// delay has elapsed in 1 ms ticks the GO lamp lights and elapsed time is
// counted directly in BCD until the button is pressed. Pressing before GO is
// a false start; letting the count reach all 9s is a timeout. The best valid
// time is kept until reset or best_clr.
//
// Counting in BCD avoids any binary-to-decimal conversion in front of the
// seven-segment multiplexer.
//
// Parameters:
//   TICK_DIV       clk cycles per 1 ms tick (>= 2)
//   DIGITS         BCD digits of result / best
//   BASE_DELAY_MS  fixed part of the pre-GO delay in ms
//   RAND_BITS      width of the random extra delay taken from the LFSR; 0 = none
//   DLY_W          delay counter width (holds BASE_DELAY_MS + 2^RAND_BITS - 1)
//
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset; aborts any trial immediately
//   bus      slave side of reaction_timer_core_if (switches in, display out)
// ---------------------------------------------------------------------------
module reaction_timer_core #(
  parameter int TICK_DIV      = 100000,
  parameter int DIGITS        = 4,
  parameter int BASE_DELAY_MS = 3000,
  parameter int RAND_BITS     = 10,
  parameter int DLY_W         = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  reaction_timer_core_if.slave  bus
);

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int RES_W  = 4 * DIGITS;

  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICK_DIV - 1);
  localparam logic [RES_W-1:0]  ALL_NINES = {DIGITS{4'h9}};
  localparam logic [DLY_W-1:0]  BASE_DLY  = DLY_W'(BASE_DELAY_MS);
  // Selects the low RAND_BITS bits of the LFSR; evaluates to zero when the
  // random part is disabled.
  localparam logic [DLY_W-1:0]  RAND_MASK = DLY_W'((32'd1 << RAND_BITS) - 32'd1);
  localparam logic [15:0]       LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN,
    ST_DONE,
    ST_FOUL,
    ST_TOUT
  } state_t;

  state_t              state_q,      state_d;
  logic                start_s1_q,   start_s1_d;
  logic                start_s2_q,   start_s2_d;
  logic                start_s3_q,   start_s3_d;
  logic                start_edge_q, start_edge_d;
  logic                button_s1_q,  button_s1_d;
  logic                button_s2_q,  button_s2_d;
  logic                button_s3_q,  button_s3_d;
  logic                button_edge_q, button_edge_d;
  logic [15:0]         lfsr_q,       lfsr_d;
  logic [TICK_W-1:0]   tick_cnt_q,   tick_cnt_d;
  logic [DLY_W-1:0]    dly_q,        dly_d;
  logic [RES_W-1:0]    result_q,     result_d;
  logic [RES_W-1:0]    best_q,       best_d;
  logic                go_led_q,     go_led_d;
  logic                busy_q,       busy_d;
  logic                foul_q,       foul_d;
  logic                timeout_q,    timeout_d;
  logic                new_best_q,   new_best_d;

  logic                tick;
  logic                lfsr_fb;
  logic [DLY_W-1:0]    rand_dly;
  logic [RES_W-1:0]    result_inc;

  // Adds one to a packed BCD number, rippling the carry through digits that
  // roll over from 9 to 0.
  function automatic logic [RES_W-1:0] bcd_inc(input logic [RES_W-1:0] v);
    logic [RES_W-1:0] r;
    logic             carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick       = (tick_cnt_q == TICK_MAX);
  assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign rand_dly   = DLY_W'(lfsr_q) & RAND_MASK;
  assign result_inc = bcd_inc(result_q);

  always_comb begin
    state_d       = state_q;
    dly_d         = dly_q;
    result_d      = result_q;
    best_d        = best_q;
    foul_d        = foul_q;
    timeout_d     = timeout_q;
    new_best_d    = 1'b0;

    // Two synchroniser stages, a history stage, then a registered edge
    // pulse so the FSM only ever sees a clean one-cycle event.
    start_s1_d    = bus.start;
    start_s2_d    = start_s1_q;
    start_s3_d    = start_s2_q;
    start_edge_d  = start_s2_q & ~start_s3_q;
    button_s1_d   = bus.button;
    button_s2_d   = button_s1_q;
    button_s3_d   = button_s2_q;
    button_edge_d = button_s2_q & ~button_s3_q;

    lfsr_d        = {lfsr_q[14:0], lfsr_fb};

    // Free-running millisecond divider; restarted on entry to ARMED and RUN
    // so each phase gets a full millisecond before its first tick.
    tick_cnt_d    = tick ? '0 : tick_cnt_q + TICK_W'(1);

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FOUL, ST_TOUT: begin
        if (start_edge_q) begin
          state_d    = ST_ARMED;
          dly_d      = BASE_DLY + rand_dly;
          result_d   = '0;
          foul_d     = 1'b0;
          timeout_d  = 1'b0;
          tick_cnt_d = '0;
        end
      end

      ST_ARMED: begin
        // A press on the very tick that would light GO still counts as a
        // false start. A loaded delay of 0 behaves like 1 so GO comes on the
        // first tick rather than wrapping the counter.
        if (button_edge_q) begin
          state_d = ST_FOUL;
          foul_d  = 1'b1;
        end else if (tick) begin
          if (dly_q <= DLY_W'(1)) begin
            state_d    = ST_RUN;
            tick_cnt_d = '0;
            dly_d      = '0;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
      end

      ST_RUN: begin
        // Press freezes the count, including when it coincides with a tick.
        // Valid BCD orders the same as plain binary of the packed nibbles,
        // so a vector compare is a most-significant-digit-first compare.
        if (button_edge_q) begin
          state_d = ST_DONE;
          if (result_q < best_q) begin
            best_d     = result_q;
            new_best_d = 1'b1;
          end
        end else if (tick) begin
          result_d = result_inc;
          if (result_inc == ALL_NINES) begin
            state_d   = ST_TOUT;
            timeout_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clearing the record overrides a simultaneous new record.
    if (bus.best_clr) begin
      best_d     = ALL_NINES;
      new_best_d = 1'b0;
    end

    go_led_d = (state_d == ST_RUN);
    busy_d   = (state_d == ST_ARMED) || (state_d == ST_RUN);
  end

  // Single register bank for the FSM, synchronisers, counters and every
  // output, so no input reaches an output without passing a flop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      start_s1_q    <= 1'b0;
      start_s2_q    <= 1'b0;
      start_s3_q    <= 1'b0;
      start_edge_q  <= 1'b0;
      button_s1_q   <= 1'b0;
      button_s2_q   <= 1'b0;
      button_s3_q   <= 1'b0;
      button_edge_q <= 1'b0;
      lfsr_q        <= LFSR_SEED;
      tick_cnt_q    <= '0;
      dly_q         <= '0;
      result_q      <= '0;
      best_q        <= ALL_NINES;
      go_led_q      <= 1'b0;
      busy_q        <= 1'b0;
      foul_q        <= 1'b0;
      timeout_q     <= 1'b0;
      new_best_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_s1_q    <= start_s1_d;
      start_s2_q    <= start_s2_d;
      start_s3_q    <= start_s3_d;
      start_edge_q  <= start_edge_d;
      button_s1_q   <= button_s1_d;
      button_s2_q   <= button_s2_d;
      button_s3_q   <= button_s3_d;
      button_edge_q <= button_edge_d;
      lfsr_q        <= lfsr_d;
      tick_cnt_q    <= tick_cnt_d;
      dly_q         <= dly_d;
      result_q      <= result_d;
      best_q        <= best_d;
      go_led_q      <= go_led_d;
      busy_q        <= busy_d;
      foul_q        <= foul_d;
      timeout_q     <= timeout_d;
      new_best_q    <= new_best_d;
    end
  end

  assign bus.result_bcd = result_q;
  assign bus.best_bcd   = best_q;
  assign bus.go_led     = go_led_q;
  assign bus.busy       = busy_q;
  assign bus.foul       = foul_q;
  assign bus.timeout    = timeout_q;
  assign bus.new_best   = new_best_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// ---------------------------------------------------------------------------
// tb_reaction_timer_core
//
// Drives two timer instances (4-digit and 2-digit) with directed and random
// trials. Expected outcomes come from a millisecond-level model: the edge on
// which the press lands relative to GO determines the reaction time in whole
// milliseconds, which is converted to BCD for comparison.
// ---------------------------------------------------------------------------
module tb_reaction_timer_core;

  localparam int T       = 4;
  localparam int BASE    = 5;
  localparam int LAT     = 3;               // pin sampled -> state change
  localparam int GO_REL  = LAT + BASE * T;  // start edge -> GO edge

  logic clk;
  logic reset_n;
  int   cyc;
  int   check_count;
  int   pass_count;
  int   model_best;

  reaction_timer_core_if #(.DIGITS(4)) if4 ();
  reaction_timer_core_if #(.DIGITS(2)) if2 ();

  reaction_timer_core #(
    .TICK_DIV(T), .DIGITS(4), .BASE_DELAY_MS(BASE), .RAND_BITS(0), .DLY_W(16)
  ) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(if4.slave)
  );

  reaction_timer_core #(
    .TICK_DIV(T), .DIGITS(2), .BASE_DELAY_MS(BASE), .RAND_BITS(0), .DLY_W(16)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Decimal value to packed BCD, units in [3:0].
  function automatic logic [31:0] toBcd(input int v);
    logic [31:0] r;
    int          rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // One trial on the 4-digit timer. Offsets are in clock edges relative to
  // the edge that first samples start high; negative means unused.
  task automatic applyStimulus(input int press_rel, input int ign_start_rel,
                               input int clr_rel);
    int  k, r, p, d, s, c, last, exp_res;
    bit  valid, nb_exp;
    k       = cyc + 1;
    p       = k + press_rel;
    d       = p + LAT;
    r       = k + GO_REL;
    s       = (ign_start_rel >= 0) ? k + ign_start_rel : -100;
    c       = (clr_rel >= 0) ? k + clr_rel : -100;
    valid   = (d > r);
    exp_res = valid ? (d - r - 1) / T : 0;
    last    = (valid ? d : r) + 2;
    while (cyc < last) begin
      int e;
      e = cyc + 1;
      if4.start    = (e == k) || (e == k + 1) || (e == s) || (e == s + 1);
      if4.button   = (e == p) || (e == p + 1);
      if4.best_clr = (e == c);
      @(negedge clk);
      if (e == k + LAT) begin
        checkOutput("armed_busy", 32'(if4.busy), 32'd1);
        checkOutput("armed_result", 32'(if4.result_bcd), 32'd0);
        checkOutput("armed_foul", 32'(if4.foul), 32'd0);
      end
      if (valid && e == r - 1) checkOutput("go_before", 32'(if4.go_led), 32'd0);
      if (valid && e == r)     checkOutput("go_at", 32'(if4.go_led), 32'd1);
      if (e == c) model_best = 9999;
      if (e == d) begin
        nb_exp = 1'b0;
        if (valid && c != d && exp_res < model_best) begin
          model_best = exp_res;
          nb_exp     = 1'b1;
        end
        checkOutput("result", 32'(if4.result_bcd), toBcd(exp_res));
        checkOutput("foul", 32'(if4.foul), 32'(!valid));
        checkOutput("busy_end", 32'(if4.busy), 32'd0);
        checkOutput("go_end", 32'(if4.go_led), 32'd0);
        checkOutput("timeout", 32'(if4.timeout), 32'd0);
        checkOutput("best", 32'(if4.best_bcd), toBcd(model_best));
        checkOutput("new_best", 32'(if4.new_best), 32'(nb_exp));
      end
      if (e == d + 1) checkOutput("new_best_off", 32'(if4.new_best), 32'd0);
      if (!valid && e == last) checkOutput("foul_no_go", 32'(if4.go_led), 32'd0);
    end
    if4.start    = 1'b0;
    if4.button   = 1'b0;
    if4.best_clr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic clearBest();
    if4.best_clr = 1'b1;
    @(negedge clk);
    if4.best_clr = 1'b0;
    model_best   = 9999;
    checkOutput("best_clr", 32'(if4.best_bcd), toBcd(model_best));
    checkOutput("best_clr_nb", 32'(if4.new_best), 32'd0);
  endtask

  task automatic resetMidRun();
    int k, r;
    k = cyc + 1;
    r = k + GO_REL;
    while (cyc < r + 5 * T) begin
      int e;
      e = cyc + 1;
      if4.start = (e == k) || (e == k + 1);
      @(negedge clk);
    end
    checkOutput("pre_reset_go", 32'(if4.go_led), 32'd1);
    checkOutput("pre_reset_result", 32'(if4.result_bcd), toBcd(5));
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    model_best = 9999;
    checkOutput("rst_go", 32'(if4.go_led), 32'd0);
    checkOutput("rst_busy", 32'(if4.busy), 32'd0);
    checkOutput("rst_result", 32'(if4.result_bcd), 32'd0);
    checkOutput("rst_best", 32'(if4.best_bcd), toBcd(9999));
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic timeoutTrial();
    int k, r, t_end;
    k     = cyc + 1;
    r     = k + GO_REL;
    t_end = r + 99 * T;
    while (cyc < t_end + 16) begin
      int e;
      e = cyc + 1;
      if2.start  = (e == k) || (e == k + 1);
      if2.button = (e == t_end + 4) || (e == t_end + 5);
      @(negedge clk);
      if (e == t_end - 1) begin
        checkOutput("tout_pre_result", 32'(if2.result_bcd), toBcd(98));
        checkOutput("tout_pre_flag", 32'(if2.timeout), 32'd0);
        checkOutput("tout_pre_busy", 32'(if2.busy), 32'd1);
      end
      if (e == t_end) begin
        checkOutput("tout_result", 32'(if2.result_bcd), toBcd(99));
        checkOutput("tout_flag", 32'(if2.timeout), 32'd1);
        checkOutput("tout_busy", 32'(if2.busy), 32'd0);
        checkOutput("tout_go", 32'(if2.go_led), 32'd0);
      end
    end
    checkOutput("tout_nowrap", 32'(if2.result_bcd), toBcd(99));
    checkOutput("tout_sticky", 32'(if2.timeout), 32'd1);
    checkOutput("tout_best", 32'(if2.best_bcd), toBcd(99));
    checkOutput("tout_no_nb", 32'(if2.new_best), 32'd0);
    if2.start  = 1'b0;
    if2.button = 1'b0;
  endtask

  initial begin
    check_count  = 0;
    pass_count   = 0;
    model_best   = 9999;
    reset_n      = 1'b0;
    if4.start    = 1'b0;
    if4.button   = 1'b0;
    if4.best_clr = 1'b0;
    if2.start    = 1'b0;
    if2.button   = 1'b0;
    if2.best_clr = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_result", 32'(if4.result_bcd), 32'd0);
    checkOutput("reset_best", 32'(if4.best_bcd), toBcd(9999));
    checkOutput("reset_flags", {27'd0, if4.go_led, if4.busy, if4.foul,
                                if4.timeout, if4.new_best}, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    applyStimulus(33, -1, -1);         // 3 ms, first record
    applyStimulus(49, -1, -1);         // 7 ms, record stays
    clearBest();
    applyStimulus(8, -1, -1);          // false start 2 ms after arming
    applyStimulus(188, 40, -1);        // 41 ms with press on a tick, start ignored
    applyStimulus(61, -1, -1);         // 10 ms, carry into tens digit
    applyStimulus(33, -1, 36);         // clear coincides with record
    applyStimulus(20, -1, -1);         // press on the final delay tick: foul
    applyStimulus(21, -1, -1);         // press right after GO: 0 ms

    for (int i = 0; i < 10; i++) begin
      int pr, cr;
      pr = int'($urandom_range(GO_REL + 60 * T, 1));
      cr = ($urandom_range(3, 0) == 0) ? int'($urandom_range(pr + 5, 1)) : -1;
      applyStimulus(pr, -1, cr);
    end

    resetMidRun();
    timeoutTrial();

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
